// File: rtl/instr_encoder.sv
// LEGv8 instruction encoder and imem loader: packs symbolic R/I/D/CB requests into
// 32-bit words and writes them at wrapping addresses. Optional checking: ENCODER_CHECK_EN.
module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rn,
  input  logic [4:0]        rm,
  input  logic [18:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL} state_t;

  state_t              state_reg, state_next;
  logic                in_ready_reg;
  logic                imem_we_reg;
  logic [ADDR_W-1:0]   imem_waddr_reg;
  logic [31:0]         imem_wdata_reg;
  logic [ADDR_W:0]     count_reg;
  logic [ADDR_W:0]     count_inc;
  logic [ADDR_W-1:0]   base_reg;
  logic [31:0]         enc_word;
  logic                is_ifmt;
  logic                is_dfmt;
  logic                accept;
  logic                reject;
  logic                write_ok;

  always_comb begin
    enc_word = 32'h0000_0000;
    is_ifmt  = 1'b0;
    is_dfmt  = 1'b0;
    case (op)
      4'd0:  enc_word = {11'b10001011000, rm, 6'b000000, rn, rd};
      4'd1:  enc_word = {11'b11001011000, rm, 6'b000000, rn, rd};
      4'd2:  enc_word = {11'b10001010000, rm, 6'b000000, rn, rd};
      4'd3:  enc_word = {11'b10101010000, rm, 6'b000000, rn, rd};
      4'd4:  begin enc_word = {10'b1001000100, imm[11:0], rn, rd}; is_ifmt = 1'b1; end
      4'd5:  begin enc_word = {10'b1101000100, imm[11:0], rn, rd}; is_ifmt = 1'b1; end
      4'd6:  begin enc_word = {10'b1001001000, imm[11:0], rn, rd}; is_ifmt = 1'b1; end
      4'd7:  begin enc_word = {10'b1011001000, imm[11:0], rn, rd}; is_ifmt = 1'b1; end
      4'd8:  begin enc_word = {11'b11111000010, imm[8:0], 2'b00, rn, rd}; is_dfmt = 1'b1; end
      4'd9:  begin enc_word = {11'b11111000000, imm[8:0], 2'b00, rn, rd}; is_dfmt = 1'b1; end
      4'd10: enc_word = {8'b10110100, imm, rd};
      default: enc_word = 32'h0000_0000;
    endcase
  end

`ifdef ENCODER_CHECK_EN
  logic err_reg;
  // D-format offsets must sign-extend cleanly out of the 9-bit field
  assign reject = (op > 4'd10)
                || (is_ifmt && (|imm[18:12]))
                || (is_dfmt && !((&imm[18:8]) || !(|imm[18:8])));
`else
  assign reject = 1'b0;
`endif

  assign accept    = in_valid && in_ready_reg && !start;
  assign write_ok  = accept && !reject;
  assign count_inc = count_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = S_RUN;
    end else if (state_reg == S_RUN && write_ok && count_inc == DEPTH) begin
      state_next = S_FULL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next == S_RUN);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_we_reg    <= 1'b0;
      imem_waddr_reg <= '0;
      imem_wdata_reg <= 32'h0000_0000;
      count_reg      <= '0;
      base_reg       <= '0;
    end else begin
      imem_we_reg <= 1'b0;
      if (start) begin
        base_reg  <= base;
        count_reg <= '0;
      end else if (write_ok) begin
        imem_we_reg    <= 1'b1;
        imem_waddr_reg <= base_reg + count_reg[ADDR_W-1:0];
        imem_wdata_reg <= enc_word;
        count_reg      <= count_inc;
      end
    end
  end

`ifdef ENCODER_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_reg <= 1'b0;
    end else if (start) begin
      err_reg <= 1'b0;
    end else if (accept && reject) begin
      err_reg <= 1'b1;
    end
  end
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign in_ready   = in_ready_reg;
  assign imem_we    = imem_we_reg;
  assign imem_waddr = imem_waddr_reg;
  assign imem_wdata = imem_wdata_reg;
  assign count      = count_reg;
  assign full       = (count_reg == DEPTH);

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder against a field-arithmetic
// reference model; a small memory (ADDR_W=2) exercises wrap and full often.
module tb_instr_encoder;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic [4:0]        rd, rn, rm;
  logic [18:0]       imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state
  bit m_active = 0;
  int m_count  = 0;
  int m_base   = 0;
  bit m_err    = 0;

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .rd(rd), .rn(rn), .rm(rm), .imm(imm),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned ref_word(input int o, input int d, input int n,
                                           input int m, input int si);
    int unsigned f12, f9, f19;
    f12 = si & 32'hFFF;
    f9  = si & 32'h1FF;
    f19 = si & 32'h7FFFF;
    case (o)
      0:  return (32'h458 << 21) + (m << 16) + (n << 5) + d;
      1:  return (32'h658 << 21) + (m << 16) + (n << 5) + d;
      2:  return (32'h450 << 21) + (m << 16) + (n << 5) + d;
      3:  return (32'h550 << 21) + (m << 16) + (n << 5) + d;
      4:  return (32'h244 << 22) + (f12 << 10) + (n << 5) + d;
      5:  return (32'h344 << 22) + (f12 << 10) + (n << 5) + d;
      6:  return (32'h248 << 22) + (f12 << 10) + (n << 5) + d;
      7:  return (32'h2C8 << 22) + (f12 << 10) + (n << 5) + d;
      8:  return (32'h7C2 << 21) + (f9 << 12) + (n << 5) + d;
      9:  return (32'h7C0 << 21) + (f9 << 12) + (n << 5) + d;
      10: return (32'hB4 << 24) + (f19 << 5) + d;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_ok(input int o, input int si);
`ifdef ENCODER_CHECK_EN
    if (o > 10) return 0;
    if (o >= 4 && o <= 7 && (si < 0 || si > 4095)) return 0;
    if ((o == 8 || o == 9) && (si < -256 || si > 255)) return 0;
    return 1;
`else
    return (o >= 0);
`endif
  endfunction

  // One clock: drive at negedge, update model on the edge, sample 1 after it.
  task automatic step(input bit s, input int b, input bit v, input int o,
                      input int d, input int n, input int m, input int si);
    bit acc, wr;
    int exp_addr;
    int unsigned exp_word;
    @(negedge clk);
    start = s; base = b[ADDR_W-1:0]; in_valid = v; op = o[3:0];
    rd = d[4:0]; rn = n[4:0]; rm = m[4:0]; imm = si[18:0];
    acc = v && m_active && (m_count < DEPTH) && !s;
    wr = acc && ref_ok(o, int'($signed(si[18:0])));
    exp_addr = (m_base + m_count) % DEPTH;
    exp_word = ref_word(o, d, n, m, int'($signed(si[18:0])));
    @(posedge clk);
    if (s) begin
      m_active = 1; m_count = 0; m_base = b % DEPTH; m_err = 0;
    end else if (wr) begin
      m_count++;
    end else if (acc) begin
      m_err = 1;
    end
    #1;
    check("we", {31'b0, imem_we}, {31'b0, wr});
    if (wr) begin
      check("waddr", {30'b0, imem_waddr}, exp_addr);
      check("wdata", imem_wdata, exp_word);
      $display("[TB] write op=%0d addr=%0d data=%h", o, imem_waddr, imem_wdata);
    end
    check("count", {29'b0, count}, m_count);
    check("full", {31'b0, full}, {31'b0, (m_count == DEPTH)});
    check("ready", {31'b0, in_ready}, {31'b0, (m_active && m_count < DEPTH)});
`ifdef ENCODER_CHECK_EN
    check("err", {31'b0, err}, {31'b0, m_err});
`else
    check("err", {31'b0, err}, 32'd0);
`endif
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0; start = 0; base = '0; in_valid = 0; op = '0;
    rd = '0; rn = '0; rm = '0; imm = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, in_ready}, 32'd0);
    check("rst_count", {29'b0, count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle();

    // R-format
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 2, 3, 0);
    check("r_add_word", imem_wdata, 32'h8B030041);

    // I/D/CB back-to-back
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 4, 9, 9, 0, 4);
    check("addi_word", imem_wdata, 32'h91001129);
    step(0, 0, 1, 8, 10, 1, 0, -8);
    check("ldur_word", imem_wdata, 32'hF85F802A);
    step(0, 0, 1, 10, 3, 0, 0, -2);
    check("cbz_word", imem_wdata, 32'hB4FFFFC3);
    check("cbz_addr", {30'b0, imem_waddr}, 32'd2);

    // wrap and full from base 2
    step(1, 2, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 3, i, i + 1, i + 2, 0);
    check("full_flag", {31'b0, full}, 32'd1);
    step(0, 0, 1, 0, 5, 5, 5, 0);
    check("full_nowrite", {31'b0, imem_we}, 32'd0);

    // start collision
    step(1, 1, 1, 0, 1, 1, 1, 0);
    check("coll_count", {29'b0, count}, 32'd0);

    // checking: out-of-range immediate and illegal op
    step(0, 0, 1, 4, 9, 9, 0, 4096);
`ifndef ENCODER_CHECK_EN
    check("addi4096_word", imem_wdata, 32'h91000129);
`endif
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 12, 1, 2, 3, 0);
    idle();

    // mid-load reset
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 7, 8, 9, 0);
    @(negedge clk);
    in_valid = 1;
    #2 reset = 1'b0;
    #1;
    m_active = 0; m_count = 0; m_err = 0;
    check("mrst_we", {31'b0, imem_we}, 32'd0);
    check("mrst_waddr", {30'b0, imem_waddr}, 32'd0);
    check("mrst_wdata", imem_wdata, 32'd0);
    check("mrst_count", {29'b0, count}, 32'd0);
    check("mrst_full", {31'b0, full}, 32'd0);
    check("mrst_ready", {31'b0, in_ready}, 32'd0);
    check("mrst_err", {31'b0, err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 0;
    idle();
    step(0, 0, 1, 0, 1, 1, 1, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int o, si;
      bit s;
      s  = ($urandom_range(0, 11) == 0);
      o  = ($urandom_range(0, 7) == 0) ? $urandom_range(11, 15) : $urandom_range(0, 10);
      si = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 600)) - 300
                                       : int'($signed(19'($urandom)));
      step(s, $urandom_range(0, DEPTH - 1), $urandom_range(0, 3) != 0, o,
           $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), si);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
